// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared types and constants for the RX frame scheduler
package rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2,
    TERM = 2'd3
  } rx_state_e;

  localparam int PRE_SOF = 32;
  localparam int SOF     = 33;
  localparam int PRE_EOF = 34;
  localparam int EOF     = 35;
  localparam int ERR     = 36;

  localparam logic [255:0] DATA_IDLE = {32{8'h07}};
  localparam logic [31:0]  CTRL_IDLE = 32'hffff_ffff;

endpackage

// File: rtl/rx_sat_cnt.sv
// rtl/rx_sat_cnt.sv - width-parameterised saturating event counter
module rx_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/rx_frame_sched.sv
// rtl/rx_frame_sched.sv - RX frame admission/write controller for the BR FIFO
// Statistics counters exist only when RX_SCHED_STATS_EN is defined.
module rx_frame_sched
  import rx_pkg::*;
#(
  parameter int MAX_FRM_WORDS = 48,
  parameter int FREE_W        = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [255:0]      din,
  input  logic [39:0]       cin,
  input  logic              din_we,
  input  logic              linkup,
  input  logic [FREE_W-1:0] fifo_free,
  output logic [255:0]      fifo_wdata,
  output logic [39:0]       fifo_wctrl,
  output logic              fifo_we,
  output logic [31:0]       frm_cnt,
  output logic [15:0]       drop_cnt,
  output logic [15:0]       abort_cnt
);

  localparam int WCNT_W = $clog2(MAX_FRM_WORDS + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MAX_FRM_WORDS);
  localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);

  rx_state_e         state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic              term_eof, term_eof_nxt;
  logic              term_noabort, term_noabort_nxt;
  logic              sofm, eofm, adm;
  logic              wr_data, wr_term;
  logic              frm_inc, drop_inc, abort_inc;
  logic              we_nxt;
  logic [255:0]      wdata_nxt;
  logic [39:0]       wctrl_nxt;

  assign sofm = din_we & cin[SOF];
  assign eofm = din_we & cin[EOF];
  assign adm  = linkup & (fifo_free >= FREE_W'(MAX_FRM_WORDS));

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wcnt         <= '0;
      term_eof     <= 1'b0;
      term_noabort <= 1'b0;
    end else begin
      state        <= state_nxt;
      wcnt         <= wcnt_nxt;
      term_eof     <= term_eof_nxt;
      term_noabort <= term_noabort_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    wcnt_nxt         = wcnt;
    term_eof_nxt     = term_eof;
    term_noabort_nxt = term_noabort;
    wr_data          = 1'b0;
    wr_term          = 1'b0;
    frm_inc          = 1'b0;
    drop_inc         = 1'b0;
    abort_inc        = 1'b0;
    case (state)
      IDLE, DROP: begin
        // DROP's closing eof word is judged like an IDLE word so a fused sof is not lost
        if ((state == IDLE) || eofm) begin
          state_nxt = IDLE;
          if (sofm) begin
            if (adm) begin
              wr_data  = 1'b1;
              wcnt_nxt = WCNT_ONE;
              if (eofm) frm_inc = 1'b1;
              else      state_nxt = PASS;
            end else begin
              drop_inc = 1'b1;
              if (!eofm) state_nxt = DROP;
            end
          end
        end
      end
      PASS: begin
        if (din_we) begin
          if (!linkup || (wcnt == WCNT_MAX)) begin
            state_nxt        = TERM;
            term_eof_nxt     = eofm;
            term_noabort_nxt = 1'b0;
          end else begin
            wr_data  = 1'b1;
            wcnt_nxt = wcnt + WCNT_ONE;
            if (eofm) begin
              frm_inc = 1'b1;
              if (!sofm) begin
                state_nxt = IDLE;
              end else if (adm) begin
                wcnt_nxt = WCNT_ONE;
              end else begin
                drop_inc         = 1'b1;
                state_nxt        = TERM;
                term_eof_nxt     = 1'b0;
                term_noabort_nxt = 1'b1;
              end
            end
          end
        end else if (!linkup) begin
          state_nxt        = TERM;
          term_eof_nxt     = 1'b0;
          term_noabort_nxt = 1'b0;
        end
      end
      TERM: begin
        wr_term   = 1'b1;
        abort_inc = ~term_noabort;
        state_nxt = (term_eof || eofm) ? IDLE : DROP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    we_nxt    = wr_data | wr_term;
    wdata_nxt = DATA_IDLE;
    wctrl_nxt = {8'h00, CTRL_IDLE};
    if (wr_data) begin
      wdata_nxt = din;
      wctrl_nxt = cin;
    end else if (wr_term) begin
      wctrl_nxt[EOF] = 1'b1;
      wctrl_nxt[ERR] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_we    <= 1'b0;
      fifo_wdata <= DATA_IDLE;
      fifo_wctrl <= {8'h00, CTRL_IDLE};
    end else begin
      fifo_we    <= we_nxt;
      fifo_wdata <= wdata_nxt;
      fifo_wctrl <= wctrl_nxt;
    end
  end

`ifdef RX_SCHED_STATS_EN
  rx_sat_cnt #(.W(32)) u_frm_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (frm_inc),
    .count (frm_cnt)
  );
  rx_sat_cnt #(.W(16)) u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (drop_inc),
    .count (drop_cnt)
  );
  rx_sat_cnt #(.W(16)) u_abort_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (abort_inc),
    .count (abort_cnt)
  );
`else
  logic unused_inc;
  assign unused_inc = frm_inc ^ drop_inc ^ abort_inc;
  assign frm_cnt    = '0;
  assign drop_cnt   = '0;
  assign abort_cnt  = '0;
`endif

endmodule
